// File: rtl/apb_slave_mem.sv
// APB completer in front of a word-addressed register memory, with PSLVERR on out-of-range addresses.
// Define APB_SLAVE_WAIT_EN to compile in the WAIT state and the WAIT_CYCLES wait-state counter.
module apb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]    addr;
  logic                write;
  logic [DATA_W-1:0]   wdata;
  logic                err;
  logic                setup_err;
  logic [IDX_W-1:0]    cur_idx;
  logic                cur_write;
  logic                cur_err;
  logic [DATA_W-1:0]   rd_data;

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0]          cnt;
`else
  wire unused_wait = (WAIT_CYCLES != 0);
`endif

  assign setup_err = (32'(PADDR) >= $unsigned(DEPTH));

  // Zero-wait transfers enter READY straight from the setup phase, so the
  // response is built from the live bus; otherwise from the setup latch.
  always_comb begin
    cur_idx   = addr;
    cur_write = write;
    cur_err   = err;
    if (state == IDLE) begin
      cur_idx   = PADDR[IDX_W-1:0];
      cur_write = PWRITE;
      cur_err   = setup_err;
    end
    rd_data = (!cur_write && !cur_err) ? mem[cur_idx] : '0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      addr    <= '0;
      write   <= 1'b0;
      wdata   <= '0;
      err     <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
      cnt     <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            addr  <= PADDR[IDX_W-1:0];
            write <= PWRITE;
            wdata <= PWDATA;
            err   <= setup_err;
`ifdef APB_SLAVE_WAIT_EN
            if (WAIT_CYCLES != 0) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end else
`endif
            begin
              state   <= READY;
              PREADY  <= 1'b1;
              PSLVERR <= cur_err;
              PRDATA  <= rd_data;
            end
          end
        end
`ifdef APB_SLAVE_WAIT_EN
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (!PSEL) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state   <= READY;
            PREADY  <= 1'b1;
            PSLVERR <= cur_err;
            PRDATA  <= rd_data;
          end
        end
`endif
        READY: begin
          state   <= IDLE;
          PREADY  <= 1'b0;
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
          // Data comes from the setup latch; access-phase PWDATA is ignored.
          if (PSEL && PENABLE && write && !err) mem[addr] <= wdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: stimulus queues expected responses, a monitor checks each PREADY beat.
module tb_apb_slave_mem;
`ifdef APB_SLAVE_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   chk = 0;
  int   fails = 0;
  bit   prev_rdy = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every PREADY beat consumes one scoreboard entry.
  always @(negedge PCLK) begin
    if (PRESET) begin
      prev_rdy = 1'b0;
    end else begin
      if (prev_rdy) begin
        check("after_ready_pready", 32'(PREADY), 32'd0);
        check("after_ready_prdata", PRDATA, 32'd0);
        check("after_ready_pslverr", 32'(PSLVERR), 32'd0);
      end
      if (PREADY === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_pready", 32'(PREADY), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("prdata", PRDATA, e.d);
          check("pslverr", 32'(PSLVERR), 32'(e.e));
          check("ready_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_rdy = (PREADY === 1'b1);
    end
  end

  // One APB transfer; returns in the PREADY cycle so the next call is back-to-back.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input bit exp_e);
    bit seen;
    @(posedge PCLK) #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    q.push_back('{exp_d, exp_e, cyc + 1 + EXP_WAIT});
    @(posedge PCLK) #1;
    PENABLE = 1'b1;
    PWDATA  = ~d;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk++;
      fails++;
      $display("FAIL timeout: no PREADY for addr %0d within 20 cycles", a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK) #1;
      PSEL = 1'b0; PENABLE = 1'b0;
    end
  endtask

  initial begin
    PRESET = 1'b1;
    PSEL = 1'($urandom); PENABLE = 1'($urandom); PWRITE = 1'($urandom);
    PADDR = 8'($urandom); PWDATA = $urandom;
    @(posedge PCLK) #1;
    PSEL = 1'($urandom); PENABLE = 1'($urandom); PWRITE = 1'($urandom);
    PADDR = 8'($urandom); PWDATA = $urandom;
    @(posedge PCLK);
    @(negedge PCLK);
    check("reset_pready", 32'(PREADY), 32'd0);
    check("reset_prdata", PRDATA, 32'd0);
    check("reset_pslverr", 32'(PSLVERR), 32'd0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;

    xfer(1'b0, 8'd5, 32'h0, 32'h0, 1'b0);
    xfer(1'b1, 8'd3, 32'h6, 32'h0, 1'b0);
    xfer(1'b0, 8'd3, 32'h0, 32'h6, 1'b0);
    idle(1);
    xfer(1'b1, 8'd7, 32'hE, 32'h0, 1'b0);
    xfer(1'b0, 8'd7, 32'h0, 32'hE, 1'b0);

    // Out of range: 22 aliases index 6 if the range check were missing.
    xfer(1'b1, 8'd22, 32'd35, 32'h0, 1'b1);
    xfer(1'b0, 8'd22, 32'h0, 32'h0, 1'b1);
    xfer(1'b0, 8'd6, 32'h0, 32'h0, 1'b0);
    xfer(1'b1, 8'd15, 32'hCAFE_0015, 32'h0, 1'b0);
    xfer(1'b0, 8'd15, 32'h0, 32'hCAFE_0015, 1'b0);
    xfer(1'b0, 8'd16, 32'h0, 32'h0, 1'b1);

    // Abort: PSEL dropped in the cycle after setup.
    idle(1);
    @(posedge PCLK) #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd2; PWDATA = 32'hAA;
    if (EXP_WAIT == 0) q.push_back('{32'h0, 1'b0, cyc + 1});
    @(posedge PCLK) #1;
    PSEL = 1'b0; PENABLE = 1'b1;
    idle(4);
    xfer(1'b0, 8'd2, 32'h0, 32'h0, 1'b0);

    // Reset during the first access cycle drops the pending write.
    idle(1);
    @(posedge PCLK) #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd4; PWDATA = 32'h55;
    @(posedge PCLK) #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    check("midreset_pready", 32'(PREADY), 32'd0);
    check("midreset_prdata", PRDATA, 32'd0);
    check("midreset_pslverr", 32'(PSLVERR), 32'd0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    idle(2);
    xfer(1'b0, 8'd4, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, 8'd3, 32'h0, 32'h0, 1'b0);
    idle(3);
    @(negedge PCLK);
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer (slave) fronting a small word-addressed register memory, the responder end of the `APB_Protocol` master's two-slave system. It accepts APB setup/access phases and inserts a programmable number of wait states via PREADY. It performs 32-bit writes and reads, and flags out-of-range addresses with PSLVERR. Two instances sit behind the master's address-MSB slave decode.

## Interface
- ADDR_W, 8, width of PADDR (word index, not byte address)
- DATA_W, 32, data width
- DEPTH, 16, number of words; valid addresses 0..DEPTH-1
- WAIT_CYCLES, 2, wait states inserted per transfer (0..15)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- PSEL  in  1  slave select from master decode
- PENABLE  in  1  access-phase qualifier
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  word address
- PWDATA  in  DATA_W  write data
- PREADY  out  1  transfer-complete, registered
- PRDATA  out  DATA_W  read data, registered, valid only while PREADY=1
- PSLVERR  out  1  error response, registered, valid only while PREADY=1

## Operation
- FSM states: IDLE, WAIT, READY.
- IDLE, on PSEL=1 & PENABLE=0 (setup phase):
  - latch PADDR, PWRITE and PWDATA;
  - compute err = (PADDR >= DEPTH);
  - go to READY if wait count is 0, else go to WAIT with cnt = WAIT_CYCLES.
- IDLE, on PSEL=0 or PENABLE=1 without a preceding setup: stay in IDLE; PREADY stays 0.
- WAIT:
  - cnt decrements each cycle;
  - cnt==1 -> READY;
  - PSEL=0 -> abort to IDLE with no write and no response.
- Entering READY registers PREADY=1, PSLVERR=err. For a read with !err, PRDATA=mem[addr]; for a write or err, PRDATA=0.
- READY lasts exactly one cycle, then returns to IDLE.
  - At that edge, if PSEL & PENABLE & write & !err: mem[addr] <= latched PWDATA.
  - If PSEL=0 in READY: abort, no write.
- Write data is taken from the setup-phase latch; PWDATA changes during the access phase are ignored.
- Error transfers never modify memory.
- Back-to-back transfers: a setup phase in the cycle after READY is accepted normally from IDLE.
- Read after write to the same address, in the next transfer, returns the new data.

## Timing
- Reset values: PREADY=0, PRDATA=0, PSLVERR=0, state=IDLE, cnt=0, all mem words=0.
- Transfer length, setup edge to completion edge:
  - wait count 0: setup cycle + 1 access cycle; PREADY high in the first PENABLE cycle;
  - wait count N: setup + N wait cycles (PREADY=0) + 1 ready cycle.
- A write commits at the rising edge that ends the PREADY=1 cycle.
- PRDATA and PSLVERR are stable for the whole PREADY=1 cycle. They return to 0 in the following cycle.
- Reset mid-transfer (any state): outputs and memory return to reset values next edge; the pending write is dropped. Reset overrides all other events in the same cycle.
- Address boundary: PADDR=DEPTH-1 is valid; PADDR=DEPTH is an error.

## Configuration
- APB_SLAVE_WAIT_EN defined: WAIT state and 4-bit counter compiled in; the WAIT_CYCLES parameter is honoured.
- Not defined: no WAIT state or counter; WAIT_CYCLES is ignored; every transfer completes in setup + 1 access cycle.

## Test plan
- Reset: PRESET=1 for 2 cycles with random bus inputs -> PREADY=0, PRDATA=0, PSLVERR=0. A subsequent read of addr 5 returns 0.
- Write/read, WAIT_CYCLES=2, macro on:
  - write addr 3, data 0x6 -> PREADY high exactly 3 cycles after setup, PSLVERR=0;
  - read addr 3 -> PRDATA=0x6 while PREADY=1.
- Macro off: write addr 7, data 0xE -> PREADY high in the first PENABLE cycle. Back-to-back read addr 7 -> 0xE.
- Out of range, DEPTH=16:
  - write addr 22, data 35 -> PSLVERR=1 with PREADY; mem unchanged;
  - read addr 22 -> PSLVERR=1, PRDATA=0;
  - addr 15 -> PSLVERR=0.
- Abort: write addr 2, data 0xAA, with PSEL dropped during WAIT -> no PREADY. Read addr 2 returns the previous value 0.
- Reset mid-transfer: write addr 4 in WAIT, PRESET asserted -> PREADY stays 0. Read addr 4 after reset returns 0.
